// File: rtl/user_uart_rx.sv
// 8N1 LSB-first UART receiver with a small show-ahead byte FIFO and a level interrupt.
module user_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          rx_i,
    input  logic                          rd_en_i,
    output logic [7:0]                    rd_data_o,
    output logic                          rx_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    output logic                          irq_o,
    input  logic                          irq_clr_i
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = PW + 1;

    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SYNC_WAIT = CW'(2);
    localparam logic [NW-1:0] DEPTH     = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_t;

    logic [1:0]    sync_q;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_req_c;
    logic          frame_set_c;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [NW-1:0] count_q, count_d;
    logic          valid_q;
    logic          full_c, pop_c, push_c, overrun_set_c, irq_set_c;
    logic          frame_err_q, overrun_q, irq_q;

    assign rx_s = sync_q[1];

    // Two-flop synchronizer for the asynchronous serial line, idles high.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: all sampling decisions are taken at cnt boundaries.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_IDLE: if (cnt_q == SYNC_WAIT && rx_s) state_d = IDLE;
            IDLE:      if (!rx_s) state_d = START;
            START:     if (cnt_q == HALF_M1) state_d = rx_s ? IDLE : DATA;
            DATA:      if (cnt_q == FULL_M1 && idx_q == 3'd7) state_d = STOP;
            STOP:      if (cnt_q == FULL_M1) state_d = rx_s ? IDLE : WAIT_IDLE;
            default:   state_d = WAIT_IDLE;
        endcase
    end

    // Per-state datapath control: bit timing counter, bit index, shift register, frame result.
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push_req_c  = 1'b0;
        frame_set_c = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                // cnt doubles as the post-reset synchronizer refill delay
                if (cnt_q != SYNC_WAIT) cnt_d = cnt_q + CW'(1);
            end
            IDLE: begin
                cnt_d = '0;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    // synchronizer is already valid after a frame error, so skip the refill wait
                    cnt_d = rx_s ? '0 : SYNC_WAIT;
                    if (rx_s) begin
                        push_req_c = 1'b1;
                    end else begin
                        frame_set_c = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Receiver datapath registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // FIFO control: a pop at full frees the slot for a simultaneous push.
    always_comb begin
        full_c        = (count_q == DEPTH);
        pop_c         = rd_en_i && (count_q != '0);
        push_c        = push_req_c && (!full_c || pop_c);
        overrun_set_c = push_req_c && full_c && !pop_c;
        count_d       = count_q + NW'(push_c) - NW'(pop_c);
        irq_set_c     = push_c || overrun_set_c || frame_set_c;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    // Sticky status flags and interrupt; a set in the same cycle as a clear wins.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (frame_set_c)    frame_err_q <= 1'b1;
            else if (irq_clr_i) frame_err_q <= 1'b0;
            if (overrun_set_c)  overrun_q <= 1'b1;
            else if (irq_clr_i) overrun_q <= 1'b0;
            if (irq_set_c)      irq_q <= 1'b1;
            else if (irq_clr_i) irq_q <= 1'b0;
        end
    end

    assign rd_data_o   = mem_q[rd_ptr_q];
    assign rx_valid_o  = valid_q;
    assign count_o     = count_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_user_uart_rx.sv
// Directed bench for user_uart_rx with a byte scoreboard (CLKS_PER_BIT=16, FIFO_DEPTH=4).
module tb_user_uart_rx;

    localparam int unsigned C = 16;
    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       irq_clr = 1'b0;
    logic [7:0] rd_data;
    logic       valid;
    logic [2:0] count;
    logic       frame_err;
    logic       overrun;
    logic       irq;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    user_uart_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .rx_i        (rx),
        .rd_en_i     (rd_en),
        .rd_data_o   (rd_data),
        .rx_valid_o  (valid),
        .count_o     (count),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .irq_o       (irq),
        .irq_clr_i   (irq_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold the line at b for n clock edges; inputs change on the falling edge.
    task automatic bit_hold(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    // Drive start, data and the stop bit up to the falling edge just before the push edge (E+153).
    task automatic rx_frame(input logic [7:0] d, input logic stop);
        bit_hold(1'b0, C);
        for (int i = 0; i < 8; i++) bit_hold(d[i], C);
        bit_hold(stop, C / 2 + 2);
    endtask

    // Whole frame through the push edge (E+154).
    task automatic send(input logic [7:0] d);
        rx_frame(d, 1'b1);
        @(negedge clk);
    endtask

    // Remainder of the stop bit after the push edge.
    task automatic tail();
        repeat (C - C / 2 - 3) @(negedge clk);
    endtask

    task automatic irq_clear();
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
    endtask

    // Compare the head against the scoreboard, then pop it.
    task automatic pop_check(input string tag);
        check({tag, "_valid"}, 32'(valid), 1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed pop expected empty scoreboard", tag);
        end else begin
            exp_b = exp_q.pop_front();
            check({tag, "_data"}, 32'(rd_data), 32'(exp_b));
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (4) @(negedge clk);
        check("rst_data", 32'(rd_data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_irq", 32'(irq), 0);
        rst = 1'b0;
        repeat (C) @(negedge clk);

        // 1: single frame, exact push edge, irq clear keeps data
        rx_frame(8'h3D, 1'b1);
        check("t1_pre_valid", 32'(valid), 0);
        check("t1_pre_count", 32'(count), 0);
        @(negedge clk);
        exp_q.push_back(8'h3D);
        check("t1_valid", 32'(valid), 1);
        check("t1_data", 32'(rd_data), 32'(exp_q[0]));
        check("t1_count", 32'(count), 1);
        check("t1_irq", 32'(irq), 1);
        tail();
        irq_clear();
        check("t1_irq_clr", 32'(irq), 0);
        check("t1_count_kept", 32'(count), 1);
        pop_check("t1_pop");
        check("t1_empty", 32'(valid), 0);
        check("t1_irq_no_reassert", 32'(irq), 0);

        // 2: five back-to-back frames into a 4-deep FIFO
        send(8'h0F); exp_q.push_back(8'h0F); tail();
        send(8'hA5); exp_q.push_back(8'hA5); tail();
        send(8'h5A); exp_q.push_back(8'h5A); tail();
        send(8'hFF); exp_q.push_back(8'hFF);
        check("t2_count4", 32'(count), 4);
        check("t2_no_ovr", 32'(overrun), 0);
        tail();
        send(8'h00);
        check("t2_count_full", 32'(count), 4);
        check("t2_ovr", 32'(overrun), 1);
        tail();
        repeat (4) pop_check("t2_pop");
        check("t2_empty", 32'(valid), 0);
        check("t2_count0", 32'(count), 0);
        irq_clear();
        check("t2_ovr_clr", 32'(overrun), 0);
        check("t2_irq_clr", 32'(irq), 0);

        // 3: framing error, line held low, then recovery
        rx_frame(8'h55, 1'b0);
        @(negedge clk);
        check("t3_ferr", 32'(frame_err), 1);
        check("t3_irq", 32'(irq), 1);
        check("t3_count", 32'(count), 0);
        bit_hold(1'b0, 3 * C);
        check("t3_low_count", 32'(count), 0);
        check("t3_low_valid", 32'(valid), 0);
        bit_hold(1'b1, C);
        irq_clear();
        check("t3_ferr_clr", 32'(frame_err), 0);
        send(8'h12); exp_q.push_back(8'h12);
        check("t3_rx_count", 32'(count), 1);
        check("t3_rx_data", 32'(rd_data), 32'(exp_q[0]));
        check("t3_rx_ferr", 32'(frame_err), 0);
        tail();
        pop_check("t3_pop");
        irq_clear();

        // 4: short low glitch is a false start
        bit_hold(1'b0, 4);
        bit_hold(1'b1, 2 * C);
        check("t4_count", 32'(count), 0);
        check("t4_ferr", 32'(frame_err), 0);
        check("t4_ovr", 32'(overrun), 0);
        check("t4_irq", 32'(irq), 0);
        send(8'hC3); exp_q.push_back(8'hC3);
        check("t4_rx_count", 32'(count), 1);
        check("t4_rx_data", 32'(rd_data), 32'(exp_q[0]));
        tail();
        pop_check("t4_pop");

        // 5: pop and irq clear on the push edge while full
        send(8'h11); exp_q.push_back(8'h11); tail();
        send(8'h22); exp_q.push_back(8'h22); tail();
        send(8'h33); exp_q.push_back(8'h33); tail();
        send(8'h44); exp_q.push_back(8'h44); tail();
        irq_clear();
        check("t5_irq_pre", 32'(irq), 0);
        rx_frame(8'h66, 1'b1);
        check("t5_full", 32'(count), 4);
        exp_b = exp_q.pop_front();
        check("t5_head", 32'(rd_data), 32'(exp_b));
        rd_en = 1'b1;
        irq_clr = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        irq_clr = 1'b0;
        exp_q.push_back(8'h66);
        check("t5_ovr", 32'(overrun), 0);
        check("t5_count", 32'(count), 4);
        check("t5_irq", 32'(irq), 1);
        check("t5_new_head", 32'(rd_data), 32'(exp_q[0]));
        tail();
        repeat (4) pop_check("t5_pop");
        irq_clear();

        // 6: reset from mid bit 3 to mid bit 6 of frame 0xAA
        bit_hold(1'b0, C);
        bit_hold(1'b0, C);
        bit_hold(1'b1, C);
        bit_hold(1'b0, C);
        bit_hold(1'b1, C / 2);
        rst = 1'b1;
        bit_hold(1'b1, C / 2);
        bit_hold(1'b0, C);
        bit_hold(1'b1, C);
        bit_hold(1'b0, C / 2);
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_irq", 32'(irq), 0);
        rst = 1'b0;
        bit_hold(1'b0, C / 2);
        bit_hold(1'b1, C);
        bit_hold(1'b1, C);
        bit_hold(1'b1, 2 * C);
        check("t6_count", 32'(count), 0);
        check("t6_valid", 32'(valid), 0);
        check("t6_irq", 32'(irq), 0);
        check("t6_ferr", 32'(frame_err), 0);
        send(8'h81); exp_q.push_back(8'h81);
        check("t6_rx_count", 32'(count), 1);
        check("t6_rx_data", 32'(rd_data), 32'(exp_q[0]));
        tail();
        pop_check("t6_pop");
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/user_uart_rx.md
# user_uart_rx

Serial UART receiver (8N1, LSB first) in the user project. It takes the `mprj_io[5]` line driven by the bench UART transmitter and deserialises bytes into a small show-ahead FIFO. A level interrupt tells firmware, through the user-project Wishbone glue, that data or an error is pending. It is the receive end of the `tbuart` transmit path.

## Interface
- `CLKS_PER_BIT`, default 16: `wb_clk_i` cycles per bit. Even, ≥4.
- `FIFO_DEPTH`, default 4: byte entries. Power of two, ≥2.
- `wb_clk_i`  in  1  clock, the only clock domain.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `rx_i`  in  1  serial line, idle high, asynchronous to `wb_clk_i`.
- `rd_en_i`  in  1  pop FIFO head. Ignored when empty.
- `rd_data_o`  out  8  FIFO head byte. Valid while `rx_valid_o`.
- `rx_valid_o`  out  1  FIFO non-empty.
- `count_o`  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `frame_err_o`  out  1  sticky: stop bit sampled 0.
- `overrun_o`  out  1  sticky: byte completed while FIFO full.
- `irq_o`  out  1  level interrupt.
- `irq_clr_i`  in  1  one-cycle pulse. Clears `irq_o`, `frame_err_o` and `overrun_o`.

## Operation
- **Input synchronizer:** 2-FF synchronizer on `rx_i`, reset value 1. Its output is `rx_s`.
- **FSM states:** WAIT_IDLE, IDLE, START, DATA, STOP. A bit counter `cnt` and a bit index `idx` (0..7) drive sampling.
- **WAIT_IDLE** (reset state):
  - Waits 2 cycles for the synchronizer to refill.
  - Moves to IDLE on the first later cycle with `rx_s`=1.
  - Stays in WAIT_IDLE while `rx_s`=0, which covers a break or a line held low.
- **IDLE:** `rx_s`=0 → START, `cnt`=0.
- **START:**
  - Samples `rx_s` at `cnt`=CLKS_PER_BIT/2−1 (mid start bit).
  - Sample 0 → DATA, `cnt`=0, `idx`=0.
  - Sample 1 → IDLE. This is a false start: no flags change, nothing is stored.
- **DATA:**
  - Samples at `cnt`=CLKS_PER_BIT−1 and shifts the bit into position `idx`.
  - `idx`=7 → STOP, `cnt`=0.
- **STOP:**
  - Samples at `cnt`=CLKS_PER_BIT−1 (mid stop bit).
  - Sample 1: push the byte if not full; if full, drop the byte and set `overrun_o`. Next state IDLE.
  - Sample 0: discard the byte, set `frame_err_o`, next state WAIT_IDLE.
- **FIFO:**
  - Registered circular buffer.
  - `rd_data_o` = mem[rd_ptr] (show-ahead).
  - Push and pop in the same cycle are both performed, and `count_o` is unchanged.
  - At full, a simultaneous pop and push is not an overrun.
  - Pop when empty does nothing.
- **irq_o:**
  - Set on any push, overrun or frame error.
  - Cleared by `irq_clr_i`.
  - If set and clear happen in the same cycle, set wins.
  - `irq_clr_i` does not touch FIFO contents.
  - `irq_o` does not re-assert on its own while the FIFO stays non-empty.
- **Arithmetic:**
  - `cnt` width is clog2(CLKS_PER_BIT).
  - Pointers wrap modulo FIFO_DEPTH.
  - `count_o` saturates at neither end: the push/pop rules keep it in range 0..FIFO_DEPTH.

## Timing
- **Reset values:**
  - `rd_data_o`=0, `rx_valid_o`=0, `count_o`=0, `frame_err_o`=0, `overrun_o`=0, `irq_o`=0.
  - FIFO empty, FSM in WAIT_IDLE, synchronizer =1.
- **Reset during a frame:** the partial byte is lost and no byte is pushed. The FSM re-arms only after `rx_s` is seen high.
- **Frame timing:** let E be the first posedge at which `rx_i`=0.
  - START is entered at E+2.
  - Data bit k is sampled at E+2+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
  - The stop bit is sampled, and the push happens, at E+2+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
  - `rx_valid_o`, `count_o` and `irq_o` update at that same edge. With the default of 16 this is E+154.
- **Back-to-back frames:** returning to IDLE at mid stop bit gives half a bit of margin to catch the next start edge.
- **Pop:** pop at edge P → `rd_data_o`, `count_o` and `rx_valid_o` reflect the new head after P.
- **All outputs are registered**, except `rd_data_o`, which is a mux of registered memory by registered pointer.

## Test plan
All scenarios use CLKS_PER_BIT=16 and FIFO_DEPTH=4.
1. Reset, then frame 0x3D → `rx_valid_o`=1 at E+154, `rd_data_o`=0x3D, `count_o`=1, `irq_o`=1. After `irq_clr_i`, `irq_o`=0 and the FIFO is still 1 deep.
2. Five back-to-back frames 0x0F, 0xA5, 0x5A, 0xFF, 0x00 with no pops → `count_o`=4 and `overrun_o`=1. Pops return 0x0F, 0xA5, 0x5A, 0xFF in that order, then `rx_valid_o`=0.
3. Frame 0x55 with stop bit 0 and the line then held low for 3 bit times → `frame_err_o`=1, `irq_o`=1, `count_o` unchanged. No byte is accepted while the line is low. After the line goes high, frame 0x12 is received correctly.
4. Low glitch on `rx_i` lasting 4 cycles → no push, no flags set, FSM back in IDLE. A following frame 0xC3 is received.
5. FIFO full, and a pop coincides with the stop-bit push edge → `overrun_o`=0, `count_o`=4, new byte at the tail. `irq_clr_i` asserted on that same edge → `irq_o` stays 1.
6. `wb_rst_i` asserted during bit 3 of frame 0xAA, with the line still mid-frame at release → no spurious byte, `count_o`=0. The next clean frame 0x81 is received.
